// File: rtl/serial_a_paralelo.sv
// Serial-to-parallel lane deserialiser: bit-granular comma hunt, then byte-aligned lock and data output.
// Outputs update on the edge sampling a byte's last bit (0 extra clk); no backpressure, one byte per DATA_W clocks.
module serial_a_paralelo #(
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] COMMA      = 8'hBC,
  parameter int                LOCK_COUNT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              byte_stb,
  output logic              active
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int CW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LOCKING = 2'd1,
    ACTIVE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]     comma_cnt_q, comma_cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              stb_q, stb_d;
  logic              active_q, active_d;

  logic [DATA_W-1:0] nxt;
  logic              is_comma;
  logic              boundary;

  // nxt is the window including the bit sampled on this edge.
  assign nxt      = {sr_q[DATA_W-2:0], data_in};
  assign sr_d     = nxt;
  assign is_comma = (nxt == COMMA);
  assign boundary = (bit_cnt_q == BW'(DATA_W - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= HUNT;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      stb_q       <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      stb_q       <= stb_d;
      active_q    <= active_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    comma_cnt_d = comma_cnt_q;
    case (state_q)
      HUNT: begin
        bit_cnt_d = '0;
        if (is_comma) begin
          comma_cnt_d = CW'(1);
          state_d     = (LOCK_COUNT <= 1) ? ACTIVE : LOCKING;
        end
      end
      LOCKING: begin
        bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_d = comma_cnt_q + 1'b1;
            if (int'(comma_cnt_q) + 1 >= LOCK_COUNT) state_d = ACTIVE;
          end else begin
            // Misaligned or corrupted comma: drop back to the bit-granular search.
            comma_cnt_d = '0;
            bit_cnt_d   = '0;
            state_d     = HUNT;
          end
        end
      end
      ACTIVE: begin
        bit_cnt_d = boundary ? '0 : bit_cnt_q + 1'b1;
      end
      default: begin
        state_d     = HUNT;
        bit_cnt_d   = '0;
        comma_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    data_d   = data_q;
    valid_d  = valid_q;
    stb_d    = 1'b0;
    active_d = active_q | (state_d == ACTIVE);
    if (state_q == ACTIVE && boundary) begin
      data_d  = nxt;
      valid_d = !is_comma;
      stb_d   = 1'b1;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign byte_stb  = stb_q;
  assign active    = active_q;

endmodule

// File: tb/tb_serial_a_paralelo.sv
// Bench for serial_a_paralelo: directed bit streams, scoreboard of expected bytes checked by a monitor.
module tb_serial_a_paralelo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_stb;
  logic       active;

  typedef struct packed {
    logic [7:0] d;
    logic       v;
  } exp_t;

  exp_t sb_q[$];
  exp_t hold = '0;
  int   checks = 0;
  int   errors = 0;

  localparam logic [7:0] BC = 8'hBC;

  serial_a_paralelo dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .byte_stb (byte_stb),
    .active   (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops on each strobe, otherwise checks the held value.
  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      hold = '0;
      sb_q.delete();
    end else if (byte_stb) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_stb: got data %0h valid %0b with nothing expected at %0t",
                 data_out, valid_out, $time);
      end else begin
        hold = sb_q.pop_front();
        check("byte_data", data_out, hold.d);
        check("byte_valid", valid_out, hold.v);
      end
    end else begin
      check("hold_data", data_out, hold.d);
      check("hold_valid", valid_out, hold.v);
    end
  end

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_data(input logic [7:0] b, input logic v);
    sb_q.push_back({b, v});
    send_byte(b);
    check("stb_at_last_bit", byte_stb, 1);
    check("data_at_last_bit", data_out, b);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"}, data_out, 0);
    check({tag, "_valid"}, valid_out, 0);
    check({tag, "_stb"}, byte_stb, 0);
    check({tag, "_active"}, active, 0);
  endtask

  // Reset pulse entirely between two clock edges; caller is at posedge+1.
  task automatic reset_pulse();
    #1 reset = 1'b0;
    #1 check_zero("async_rst");
    #1 reset = 1'b1;
  endtask

  task automatic lock_sequence(input string tag);
    for (int k = 1; k <= 4; k++) begin
      send_byte(BC);
      check({tag, "_active"}, active, (k == 4) ? 1 : 0);
      check({tag, "_data"}, data_out, 0);
      check({tag, "_stb"}, byte_stb, 0);
    end
  endtask

  initial begin
    // Held in reset with random input.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      data_in = 1'($urandom_range(0, 1));
      check_zero("in_reset");
    end
    #2 reset = 1'b1;
    for (int i = 0; i < 12; i++) send_bit(1'b0);
    check_zero("post_release");

    // Garbage bits, then lock on four aligned commas.
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    lock_sequence("lock1");
    check("lock1_valid", valid_out, 0);

    // Data bytes after lock.
    send_data(8'h00, 1'b1);
    send_data(8'h0E, 1'b1);
    send_data(8'h4E, 1'b1);

    // Comma while locked carries valid=0 and keeps the lane active.
    send_data(BC, 1'b0);
    check("comma_keeps_active", active, 1);
    send_data(8'hC0, 1'b1);
    check("data_keeps_active", active, 1);

    // Mid-byte async reset, then a fresh lock is required.
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    reset_pulse();
    lock_sequence("relock");
    send_data(8'h5A, 1'b1);

    // Interrupted lock: two commas, a data byte, then four commas.
    reset_pulse();
    send_byte(BC);
    send_byte(BC);
    check("partial_lock_active", active, 0);
    send_byte(8'h0E);
    check("broken_lock_active", active, 0);
    lock_sequence("lock2");
    send_data(8'h3C, 1'b1);

    repeat (2) @(negedge clk);
    #1;
    check("scoreboard_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
